data_demux: RTL

Receive-side time-division demultiplexer that restores up to three 8-bit byte streams (DS1..DS3) from one multiplexed byte lane. The lane carries fixed-length slots of `switch_clk_cycles` clocks each, and the `mode` encoding is shared with the transmit-side `data_mux`. The block locks to a start-of-frame strobe, counts slots and dwell cycles, and emits one captured byte per active slot with a valid pulse. It sits at the far end of the mux link, before per-stream consumers.

---
 rtl/data_mux_pkg.sv | 24 ++
 rtl/slot_counter.sv | 54 +++++
 rtl/data_demux.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/data_mux_pkg.sv
// rtl/data_mux_pkg.sv - shared mode/state encodings for the data_mux / data_demux pair
package data_mux_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_1   = 2'd1,
        MODE_2   = 2'd2,
        MODE_3   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

    // A dwell of zero clocks is meaningless on the lane, so it behaves as one.
    function automatic logic [2:0] eff_dwell(input logic [2:0] n);
        return (n == 3'd0) ? 3'd1 : n;
    endfunction

endpackage

// File: rtl/slot_counter.sv
// rtl/slot_counter.sv - slot/dwell position tracker for the demux frame
module slot_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [2:0] i_n,
    input  logic [1:0] i_m,
    output logic [1:0] o_slot,
    output logic [2:0] o_cyc,
    output logic       o_slot_start,
    output logic       o_frame_end
);

    logic [1:0] r_slot;
    logic [2:0] r_cyc;
    logic [1:0] w_slot_base;
    logic [2:0] w_cyc_base;
    logic [1:0] w_slot_nxt;
    logic [2:0] w_cyc_nxt;

    // A load marks the current cycle as slot 0 / cyc 0, so advance from there.
    always_comb begin
        w_slot_base = i_load ? 2'd0 : r_slot;
        w_cyc_base  = i_load ? 3'd0 : r_cyc;
        w_slot_nxt  = w_slot_base;
        w_cyc_nxt   = w_cyc_base + 3'd1;
        if (w_cyc_base == i_n - 3'd1) begin
            w_cyc_nxt  = 3'd0;
            w_slot_nxt = (w_slot_base == i_m - 2'd1) ? 2'd0 : w_slot_base + 2'd1;
        end
        if (!i_load && !i_en) begin
            w_slot_nxt = 2'd0;
            w_cyc_nxt  = 3'd0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot <= 2'd0;
            r_cyc  <= 3'd0;
        end else begin
            r_slot <= w_slot_nxt;
            r_cyc  <= w_cyc_nxt;
        end
    end

    assign o_slot       = r_slot;
    assign o_cyc        = r_cyc;
    assign o_slot_start = (r_cyc == 3'd0);
    // Opening cycle of the frame's final slot: its capture closes the frame.
    assign o_frame_end  = (r_cyc == 3'd0) && (r_slot == i_m - 2'd1);

endmodule

// File: rtl/data_demux.sv
// rtl/data_demux.sv - receive-side TDM demultiplexer restoring up to three byte streams
module data_demux
    import data_mux_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_mux_data,
    input  logic             i_sof,
    input  logic [1:0]       i_mode,
    input  logic [2:0]       i_switch_clk_cycles,
    output logic [WIDTH-1:0] o_ds1_out,
    output logic [WIDTH-1:0] o_ds2_out,
    output logic [WIDTH-1:0] o_ds3_out,
    output logic [2:0]       o_ds_valid,
    output logic             o_frame_done,
    output logic             o_locked,
    output logic             o_sync_err
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0]       r_m;
    logic [2:0]       r_n;
    logic [WIDTH-1:0] r_ds1;
    logic [WIDTH-1:0] r_ds2;
    logic [WIDTH-1:0] r_ds3;
    logic [2:0]       r_ds_valid;
    logic             r_frame_done;
    logic             r_sync_err;

    logic [2:0]       w_eff_n;
    logic             w_mode_on;
    logic             w_cfg_chg;
    logic             w_load;
    logic             w_cap;
    logic [1:0]       w_cap_slot;
    logic             w_sync_err;
    logic             w_frame_done;
    logic             w_cnt_en;
    logic [2:0]       w_cnt_n;
    logic [1:0]       w_cnt_m;
    logic [1:0]       w_slot;
    logic [2:0]       w_cyc;
    logic             w_slot_start;
    logic             w_frame_end;

    assign w_eff_n   = eff_dwell(i_switch_clk_cycles);
    assign w_mode_on = (i_mode != MODE_OFF);
    assign w_cfg_chg = (i_mode != r_m) || (w_eff_n != r_n);

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_cap        = 1'b0;
        w_cap_slot   = w_slot;
        w_sync_err   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mode_on) w_state_nxt = ST_HUNT;
            end
            ST_HUNT: begin
                if (!w_mode_on) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_sof) begin
                    w_state_nxt  = ST_LOCK;
                    w_load       = 1'b1;
                    w_cap        = 1'b1;
                    w_cap_slot   = 2'd0;
                    w_frame_done = (i_mode == MODE_1);
                end
            end
            ST_LOCK: begin
                // Config change wins over both sof handling and the capture due now.
                if (!w_mode_on) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cfg_chg) begin
                    w_state_nxt = ST_HUNT;
                end else if (i_sof && !(w_slot == 2'd0 && w_cyc == 3'd0)) begin
                    w_sync_err   = 1'b1;
                    w_load       = 1'b1;
                    w_cap        = 1'b1;
                    w_cap_slot   = 2'd0;
                    w_frame_done = (r_m == MODE_1);
                end else if (w_slot_start) begin
                    w_cap        = 1'b1;
                    w_frame_done = w_frame_end;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_cnt_en = (r_state == ST_LOCK) && (w_state_nxt == ST_LOCK);
    assign w_cnt_n  = w_load ? w_eff_n : r_n;
    assign w_cnt_m  = w_load ? i_mode  : r_m;

    slot_counter u_slot_counter (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (w_load),
        .i_en         (w_cnt_en),
        .i_n          (w_cnt_n),
        .i_m          (w_cnt_m),
        .o_slot       (w_slot),
        .o_cyc        (w_cyc),
        .o_slot_start (w_slot_start),
        .o_frame_end  (w_frame_end)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_m          <= 2'd0;
            r_n          <= 3'd1;
            r_ds1        <= '0;
            r_ds2        <= '0;
            r_ds3        <= '0;
            r_ds_valid   <= 3'b000;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ds_valid   <= 3'b000;
            r_frame_done <= w_frame_done;
            r_sync_err   <= w_sync_err;
            if (w_load) begin
                r_m <= i_mode;
                r_n <= w_eff_n;
            end
            if (w_cap) begin
                case (w_cap_slot)
                    2'd0: begin
                        r_ds1      <= i_mux_data;
                        r_ds_valid <= 3'b001;
                    end
                    2'd1: begin
                        r_ds2      <= i_mux_data;
                        r_ds_valid <= 3'b010;
                    end
                    2'd2: begin
                        r_ds3      <= i_mux_data;
                        r_ds_valid <= 3'b100;
                    end
                    default: r_ds_valid <= 3'b000;
                endcase
            end
        end
    end

    assign o_ds1_out    = r_ds1;
    assign o_ds2_out    = r_ds2;
    assign o_ds3_out    = r_ds3;
    assign o_ds_valid   = r_ds_valid;
    assign o_frame_done = r_frame_done;
    assign o_locked     = (r_state == ST_LOCK);
    assign o_sync_err   = r_sync_err;

endmodule
